// File: rtl/seven_seg_scanner.sv
// Common-anode seven-segment scanner: buffers a packed BCD word, commits it at
// frame boundaries, and scans one digit at a time with optional leading-zero blanking.

module seven_seg_digit (
    input  logic [3:0] nib,
    input  logic       blank,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'b0111111;                 // nibbles 10-15 show a dash
        if (blank) begin
            seg = 7'b1111111;
        end else begin
            case (nib)
                4'd0: seg = 7'b1000000;
                4'd1: seg = 7'b1111001;
                4'd2: seg = 7'b0100100;
                4'd3: seg = 7'b0110000;
                4'd4: seg = 7'b0011001;
                4'd5: seg = 7'b0010010;
                4'd6: seg = 7'b0000010;
                4'd7: seg = 7'b1111000;
                4'd8: seg = 7'b0000000;
                4'd9: seg = 7'b0010000;
                default: seg = 7'b0111111;
            endcase
        end
    end
endmodule

module seven_seg_scanner #(
    parameter int NUM_DIGITS   = 8,
    parameter int COUNT_PERIOD = 100000
) (
    input  logic                    clk_in,
    input  logic                    rst_in_n,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    valid_in,
    input  logic                    blank_lz_in,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic [6:0]              cat_out,
    output logic                    frame_out
);
    localparam int TW = (COUNT_PERIOD > 1) ? $clog2(COUNT_PERIOD) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [4*NUM_DIGITS-1:0]      pending_reg, disp_reg;
    logic                         pending_flag;
    logic [TW-1:0]                tick_cnt;
    logic [IW-1:0]                digit_idx;
    logic                         live;   // low for the first edge after reset so outputs stay off
    logic [NUM_DIGITS-1:0]        lz, blank_vec;
    logic [NUM_DIGITS-1:0][6:0]   seg_all;
    logic                         tick_last, digit_last, frame_hit;

    assign tick_last  = (tick_cnt == TW'(COUNT_PERIOD - 1));
    assign digit_last = (digit_idx == IW'(NUM_DIGITS - 1));
    assign frame_hit  = tick_last & digit_last;

    // lz[k]: digits k..top are all zero; invalid nibbles are nonzero so they stop blanking
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
        assign lz[k] = ~|disp_reg[4*NUM_DIGITS-1:4*k];
        if (k == 0) begin : g_ones
            assign blank_vec[k] = 1'b0;
        end else begin : g_upper
            assign blank_vec[k] = blank_lz_in & lz[k];
        end
        seven_seg_digit u_dig (
            .nib   (disp_reg[4*k +: 4]),
            .blank (blank_vec[k]),
            .seg   (seg_all[k])
        );
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in_n) begin
            pending_reg  <= '0;
            pending_flag <= 1'b0;
            disp_reg     <= '0;
            tick_cnt     <= '0;
            digit_idx    <= '0;
            live         <= 1'b0;
            an_out       <= '1;
            cat_out      <= 7'b1111111;
            frame_out    <= 1'b0;
        end else begin
            live      <= 1'b1;
            frame_out <= frame_hit;
            tick_cnt  <= tick_last ? '0 : tick_cnt + 1'b1;
            if (tick_last)
                digit_idx <= digit_last ? '0 : digit_idx + 1'b1;
            if (frame_hit && pending_flag) begin
                disp_reg     <= pending_reg;
                pending_flag <= 1'b0;
            end
            // a capture in the boundary cycle overrides the flag clear above
            if (valid_in) begin
                pending_reg  <= bcd_in;
                pending_flag <= 1'b1;
            end
            if (live) begin
                an_out  <= ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << digit_idx);
                cat_out <= seg_all[digit_idx];
            end
        end
    end
endmodule
